program_counter_ras: RTL and testbench
======================================

// Module: program_counter_ras
// PURPOSE
//  Parametrised program counter for the MIPS core: holds the fetch address, advances it by STEP,
//  and redirects on taken branch, jump, register jump, call and return. Adds a circular
//  return-address stack (RAS) so call/return pairs resolve without the register file. Feeds
//  the instruction memory address and the PC+STEP link value.
// PARAMETERS
//  ADDR_W       32  width of every address/PC signal
//  STEP         1   sequential increment (1 = word-addressed memory)
//  RESET_VECTOR 0   PC value loaded on reset
//  RAS_DEPTH    8   RAS entries, power of two, >=2
// PORTS
//  clock         in  1       single clock, all state updates on posedge
//  reset         in  1       synchronous, active-low; acts on posedge when 0
//  halt          in  1       freeze PC and RAS, level-sensitive
//  stall         in  1       freeze PC and RAS (memory/input wait), level-sensitive
//  branch_en     in  1       conditional branch instruction
//  zero          in  1       ALU zero flag; branch taken = branch_en & zero
//  branch_target in  ADDR_W  taken-branch destination
//  jump_en       in  1       unconditional jump to jump_target
//  call_en       in  1       jump to jump_target and push pc_out+STEP
//  jump_target   in  ADDR_W  jump/call destination
//  jr_en         in  1       register jump to jr_target
//  ret_en        in  1       pop RAS and jump to popped address
//  jr_target     in  ADDR_W  register value; also fallback target on RAS underflow
//  pc_out        out ADDR_W  current fetch address
//  pc_link       out ADDR_W  pc_out+STEP, combinational
//  ras_count     out $clog2(RAS_DEPTH)+1  valid RAS entries
//  ras_overflow  out 1       sticky: push occurred while full
//  ras_underflow out 1       sticky: pop occurred while empty
// BEHAVIOUR
//  Reset (reset==0 at posedge): pc_out<=RESET_VECTOR, ras_count<=0, RAS pointer<=0,
//   ras_overflow<=0, ras_underflow<=0. Overrides everything, including mid-call/return.
//  Priority per posedge (first match wins): reset > halt > stall > ret_en > jr_en >
//   call_en > jump_en > taken branch > sequential.
//  halt or stall: pc_out, RAS contents, count and flags hold; redirect inputs ignored.
//  ret_en: count>0 -> pc_out<=RAS top, pointer decrements, count-1.
//   count==0 -> pc_out<=jr_target, ras_underflow<=1, RAS unchanged.
//  jr_en: pc_out<=jr_target; RAS untouched.
//  call_en: pc_out<=jump_target; push pc_out+STEP at pointer, pointer increments mod
//   RAS_DEPTH. count<RAS_DEPTH -> count+1; count==RAS_DEPTH -> oldest entry overwritten,
//   count stays RAS_DEPTH, ras_overflow<=1.
//  jump_en: pc_out<=jump_target. Taken branch: pc_out<=branch_target.
//  Sequential: pc_out<=pc_out+STEP, truncated to ADDR_W (wraps 2^ADDR_W-STEP -> 0).
//  Simultaneous ret_en+call_en: ret wins, no push. Lower-priority enables are dropped.
//  Latency: redirect visible on pc_out one cycle after the enabling posedge.
//  Sticky flags clear only on reset. pc_link always pc_out+STEP (mod 2^ADDR_W).
// TESTING
//  reset=0 two cycles, then 1, no enables -> pc_out 0,0,1,2,3; flags 0, count 0.
//  Preset pc via jump to 0xFFFFFFFF, sequential -> next pc_out 0x00000000.
//  branch_en=1 zero=0 at pc 5 -> 6; branch_en=1 zero=1 target 0x40 -> 0x40.
//  call 0x100 at pc 3, call 0x200 at 0x100, ret, ret -> 0x100,0x200,0x101,4; count 1,2,1,0.
//  9 calls with RAS_DEPTH=8 -> ras_overflow=1, count 8; 8 rets return most recent 8 links;
//   9th ret with jr_target=0x77 -> pc 0x77, ras_underflow=1.
//  halt=1 with jump_en (pc holds), stall=1 with ret_en (count holds); reset=0 mid-nest
//   -> pc RESET_VECTOR, count 0, flags 0.

Source files
------------

// File: rtl/program_counter_ras.sv
// Program counter with a circular return-address stack.
// Holds the fetch address, advances it by STEP, and redirects on a taken
// branch, a jump, a register jump, a call or a return. Calls push pc_out+STEP
// onto the RAS and returns pop it, so call/return pairs never need the register
// file.
module program_counter_ras #(
    parameter int                 ADDR_W       = 32,
    parameter int                 STEP         = 1,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
    parameter int                 RAS_DEPTH    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         halt,
    input  logic                         stall,
    input  logic                         branch_en,
    input  logic                         zero,
    input  logic [ADDR_W-1:0]            branch_target,
    input  logic                         jump_en,
    input  logic                         call_en,
    input  logic [ADDR_W-1:0]            jump_target,
    input  logic                         jr_en,
    input  logic                         ret_en,
    input  logic [ADDR_W-1:0]            jr_target,
    output logic [ADDR_W-1:0]            pc_out,
    output logic [ADDR_W-1:0]            pc_link,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    // One action per cycle, picked by the fixed redirect priority.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_RET,
        ACT_JR,
        ACT_CALL,
        ACT_JUMP,
        ACT_BRANCH,
        ACT_SEQ
    } action_t;

    action_t             act;
    logic [ADDR_W-1:0]   ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_next;
    logic [CNT_W-1:0]    count_next;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W-1:0]   ras_top;
    logic                push;
    logic                overflow_next;
    logic                underflow_next;

    // Link value is simply the sequential successor, wrapping at 2^ADDR_W.
    assign pc_link = pc_out + ADDR_W'(STEP);

    // ptr always names the next free slot, so the top entry sits one below it.
    assign ras_top = ras_mem[ptr - PTR_ONE];

    // Priority decode: halt/stall freeze everything, then ret > jr > call > jump > branch.
    always_comb begin
        act = ACT_SEQ;
        if (halt || stall)            act = ACT_HOLD;
        else if (ret_en)              act = ACT_RET;
        else if (jr_en)               act = ACT_JR;
        else if (call_en)             act = ACT_CALL;
        else if (jump_en)             act = ACT_JUMP;
        else if (branch_en && zero)   act = ACT_BRANCH;
    end

    // Next-state computation for PC, stack pointer, occupancy and sticky flags.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves
        // a signal unassigned and no latch is inferred.
        pc_next        = pc_link;
        ptr_next       = ptr;
        count_next     = ras_count;
        overflow_next  = ras_overflow;
        underflow_next = ras_underflow;
        push           = 1'b0;
        case (act)
            ACT_HOLD: pc_next = pc_out;
            ACT_RET: begin
                if (ras_count != '0) begin
                    pc_next    = ras_top;
                    ptr_next   = ptr - PTR_ONE;
                    count_next = ras_count - CNT_ONE;
                end else begin
                    pc_next        = jr_target;
                    underflow_next = 1'b1;
                end
            end
            ACT_JR:     pc_next = jr_target;
            ACT_CALL: begin
                pc_next  = jump_target;
                push     = 1'b1;
                ptr_next = ptr + PTR_ONE;
                if (ras_count == CNT_FULL) overflow_next = 1'b1;
                else                       count_next    = ras_count + CNT_ONE;
            end
            ACT_JUMP:   pc_next = jump_target;
            ACT_BRANCH: pc_next = branch_target;
            default:    pc_next = pc_link;
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            pc_out        <= RESET_VECTOR;
            ptr           <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc_out        <= pc_next;
            ptr           <= ptr_next;
            ras_count     <= count_next;
            ras_overflow  <= overflow_next;
            ras_underflow <= underflow_next;
        end
    end

    // RAS storage: write the link at the free slot on a call.
    always_ff @(posedge clock) begin
        // NOTE: the stack array is deliberately not reset; ras_count gates every
        // read, so stale entries are never observed and the array maps to plain RAM.
        if (reset && push) ras_mem[ptr] <= pc_link;
    end

endmodule

// File: tb/tb_program_counter_ras.sv
// Directed testbench for program_counter_ras: a table of single-cycle vectors
// followed by hand-written overflow/underflow, freeze and mid-nest reset sequences.
module tb_program_counter_ras;

    logic        clock = 1'b0;
    logic        reset, halt, stall, branch_en, zero, jump_en, call_en, jr_en, ret_en;
    logic [31:0] branch_target, jump_target, jr_target;
    logic [31:0] pc_out, pc_link;
    logic [3:0]  ras_count;
    logic        ras_overflow, ras_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    program_counter_ras #(
        .ADDR_W(32), .STEP(1), .RESET_VECTOR(32'h0), .RAS_DEPTH(8)
    ) dut (
        .clock(clock), .reset(reset), .halt(halt), .stall(stall),
        .branch_en(branch_en), .zero(zero), .branch_target(branch_target),
        .jump_en(jump_en), .call_en(call_en), .jump_target(jump_target),
        .jr_en(jr_en), .ret_en(ret_en), .jr_target(jr_target),
        .pc_out(pc_out), .pc_link(pc_link), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    // rst is the raw active-low reset level; expected values are after the edge.
    typedef struct {
        logic        rst;
        logic        halt;
        logic        stall;
        logic        br;
        logic        zero;
        logic [31:0] bt;
        logic        jmp;
        logic        call;
        logic [31:0] jt;
        logic        jr;
        logic        ret;
        logic [31:0] jrt;
        logic [31:0] pc;
        int          cnt;
        logic        ovf;
        logic        unf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t idle(input logic [31:0] pc, input int cnt, input logic ovf, input logic unf);
        vec_t v;
        v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
              pc, cnt, ovf, unf};
        return v;
    endfunction

    // Apply one vector, clock it, then compare 1 time unit after the edge.
    task automatic step(input vec_t v, input string tag);
        reset = v.rst; halt = v.halt; stall = v.stall;
        branch_en = v.br; zero = v.zero; branch_target = v.bt;
        jump_en = v.jmp; call_en = v.call; jump_target = v.jt;
        jr_en = v.jr; ret_en = v.ret; jr_target = v.jrt;
        @(posedge clock);
        #1;
        check({tag, " pc"},        pc_out,               v.pc);
        check({tag, " link"},      pc_link,              v.pc + 32'd1);
        check({tag, " count"},     {28'h0, ras_count},   32'(v.cnt));
        check({tag, " overflow"},  {31'h0, ras_overflow},  {31'h0, v.ovf});
        check({tag, " underflow"}, {31'h0, ras_underflow}, {31'h0, v.unf});
    endtask

    vec_t        vecs [21];
    logic [31:0] links [9];
    vec_t        v;

    initial begin
        //          rst halt stl br  z   bt          jmp call jt            jr  ret jrt        | pc            cnt ovf unf
        vecs[0]  = '{0, 0, 0, 0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 32'h0,       32'h0,         0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 32'h0,       32'h0,         0, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 32'h0,       32'h1,         0, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 32'h0,       32'h2,         0, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 32'h0,       32'h3,         0, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 0, 32'h0,       0, 1, 32'h100,       0, 0, 32'h0,       32'h100,       1, 0, 0};
        vecs[6]  = '{1, 0, 0, 0, 0, 32'h0,       0, 1, 32'h200,       0, 0, 32'h0,       32'h200,       2, 0, 0};
        vecs[7]  = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h0,         0, 1, 32'h0,       32'h101,       1, 0, 0};
        vecs[8]  = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h0,         0, 1, 32'h0,       32'h4,         0, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 32'h0,       32'h5,         0, 0, 0};
        vecs[10] = '{1, 0, 0, 1, 0, 32'h40,      0, 0, 32'h0,         0, 0, 32'h0,       32'h6,         0, 0, 0};
        vecs[11] = '{1, 0, 0, 1, 1, 32'h40,      0, 0, 32'h0,         0, 0, 32'h0,       32'h40,        0, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 0, 32'h0,       1, 0, 32'hFFFFFFFF,  0, 0, 32'h0,       32'hFFFFFFFF,  0, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 32'h0,       32'h0,         0, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h0,         1, 0, 32'h300,     32'h300,       0, 0, 0};
        vecs[15] = '{1, 1, 0, 0, 0, 32'h0,       1, 0, 32'h500,       0, 0, 32'h0,       32'h300,       0, 0, 0};
        vecs[16] = '{1, 0, 1, 0, 0, 32'h0,       1, 0, 32'h500,       0, 0, 32'h0,       32'h300,       0, 0, 0};
        vecs[17] = '{1, 0, 0, 1, 1, 32'h600,     1, 0, 32'h500,       0, 0, 32'h0,       32'h500,       0, 0, 0};
        vecs[18] = '{1, 0, 0, 0, 0, 32'h0,       0, 1, 32'h10,        0, 0, 32'h0,       32'h10,        1, 0, 0};
        vecs[19] = '{1, 0, 0, 0, 0, 32'h0,       0, 1, 32'h20,        0, 1, 32'h0,       32'h501,       0, 0, 0};
        vecs[20] = '{1, 0, 0, 0, 0, 32'h0,       0, 1, 32'h40,        1, 0, 32'h30,      32'h30,        0, 0, 0};

        for (int i = 0; i < 21; i++) step(vecs[i], $sformatf("vec%0d", i));

        // Nine calls into an 8-deep stack from pc 0x30: the first link (0x31)
        // gets overwritten, the remaining eight come back newest first.
        for (int i = 0; i < 9; i++) begin
            links[i] = (i == 0) ? 32'h31 : 32'h1000 + 32'(16 * (i - 1)) + 32'h1;
            v = idle(32'h1000 + 32'(16 * i), (i < 8) ? i + 1 : 8, (i == 8), 1'b0);
            v.call = 1'b1;
            v.jt   = 32'h1000 + 32'(16 * i);
            step(v, $sformatf("ovf_call%0d", i));
        end
        for (int k = 0; k < 8; k++) begin
            v = idle(links[8 - k], 7 - k, 1'b1, 1'b0);
            v.ret = 1'b1;
            step(v, $sformatf("ovf_ret%0d", k));
        end
        v = idle(32'h77, 0, 1'b1, 1'b1);
        v.ret = 1'b1; v.jrt = 32'h77;
        step(v, "underflow_ret");

        // Stall with a pending return, halt with a pending jump: nothing moves.
        v = idle(32'h80, 1, 1'b1, 1'b1); v.call = 1'b1; v.jt = 32'h80;
        step(v, "pre_stall_call");
        v = idle(32'h80, 1, 1'b1, 1'b1); v.stall = 1'b1; v.ret = 1'b1;
        step(v, "stall_ret");
        v = idle(32'h80, 1, 1'b1, 1'b1); v.halt = 1'b1; v.jmp = 1'b1; v.jt = 32'h90;
        step(v, "halt_jump");

        // Reset in the middle of a call nest, even with a return requested.
        v = idle(32'h90, 2, 1'b1, 1'b1); v.call = 1'b1; v.jt = 32'h90;
        step(v, "nest_call");
        v = idle(32'h0, 0, 1'b0, 1'b0); v.rst = 1'b0; v.ret = 1'b1;
        step(v, "mid_nest_reset");
        step(idle(32'h1, 0, 1'b0, 1'b0), "post_reset_seq");
        v = idle(32'hA0, 1, 1'b0, 1'b0); v.call = 1'b1; v.jt = 32'hA0;
        step(v, "post_reset_call");
        v = idle(32'h2, 0, 1'b0, 1'b0); v.ret = 1'b1;
        step(v, "post_reset_ret");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
